// File: rtl/ring_counter_checker.sv
// Receive-side monitor for a one-hot ring counter: decodes the active bit,
// checks rotation order, tracks lock, and counts sequence violations.
module ring_counter_checker #(
  parameter int WIDTH    = 8,
  parameter int IDXW     = 3,
  parameter int LOCK_CNT = 4,
  parameter int ERRW     = 8,
  parameter int DIR      = 0
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] counter,
  output logic             valid,
  output logic [IDXW-1:0]  index,
  output logic             locked,
  output logic             seq_err,
  output logic             wrap,
  output logic [ERRW-1:0]  err_count
);

  localparam int RUNW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [RUNW-1:0]   run_q, run_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic              prev_ok_q, prev_ok_d;
  logic              valid_q, valid_d;
  logic [IDXW-1:0]   index_q, index_d;
  logic              seq_err_q, seq_err_d;
  logic              wrap_q, wrap_d;
  logic [ERRW-1:0]   err_count_q, err_count_d;

  logic              onehot;
  logic              seq_ok;
  logic              wrap_edge;
  logic [WIDTH-1:0]  succ;
  logic [IDXW-1:0]   enc;

  // Sample decode: one-hot test, binary encode, expected successor of prev.
  always_comb begin
    onehot = (counter != '0) && ((counter & (counter - WIDTH'(1))) == '0);
    enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (counter[i]) enc = IDXW'(i);
    end
    if (DIR == 0) begin
      succ      = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
      wrap_edge = prev_q[WIDTH-1] & counter[0];
    end else begin
      succ      = {prev_q[0], prev_q[WIDTH-1:1]};
      wrap_edge = prev_q[0] & counter[WIDTH-1];
    end
    seq_ok = onehot && prev_ok_q && (counter == succ);
  end

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    prev_d      = counter;
    prev_ok_d   = onehot;
    valid_d     = onehot;
    index_d     = onehot ? enc : index_q;
    seq_err_d   = 1'b0;
    wrap_d      = 1'b0;
    err_count_d = err_count_q;

    unique case (state_q)
      HUNT: begin
        if (onehot) begin
          state_d = CONFIRM;
          run_d   = '0;
        end
      end
      CONFIRM: begin
        if (seq_ok) begin
          run_d = run_q + RUNW'(1);
          if (run_q + RUNW'(1) == RUNW'(LOCK_CNT)) state_d = LOCKED;
        end else if (onehot) begin
          run_d = '0;
        end else begin
          state_d = HUNT;
        end
      end
      LOCKED: begin
        if (seq_ok) begin
          wrap_d = wrap_edge;
        end else begin
          seq_err_d = 1'b1;
          if (err_count_q != '1) err_count_d = err_count_q + ERRW'(1);
          run_d   = '0;
          state_d = onehot ? CONFIRM : HUNT;
        end
      end
      default: begin
        state_d = HUNT;
        run_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q     <= HUNT;
      run_q       <= '0;
      prev_q      <= '0;
      prev_ok_q   <= 1'b0;
      valid_q     <= 1'b0;
      index_q     <= '0;
      seq_err_q   <= 1'b0;
      wrap_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      prev_q      <= prev_d;
      prev_ok_q   <= prev_ok_d;
      valid_q     <= valid_d;
      index_q     <= index_d;
      seq_err_q   <= seq_err_d;
      wrap_q      <= wrap_d;
      err_count_q <= err_count_d;
    end
  end

  assign valid     = valid_q;
  assign index     = index_q;
  assign locked    = (state_q == LOCKED);
  assign seq_err   = seq_err_q;
  assign wrap      = wrap_q;
  assign err_count = err_count_q;

endmodule
